// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank divider channels: state encoding,
// ratio floor and default sizing.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } div_state_e;

    localparam int MIN_DIV   = 2;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_RATIO = 16;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/HIGH/LOW sequencer with a ratio register and a
// pending ratio that is adopted only when a new period starts.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_RATIO
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             align_i,
    input  logic             div_we_i,
    input  logic [DIV_W-1:0] div_val_i,
    output logic             clk_div_o,
    output logic             tick_o,
    output logic             pend_o,
    output logic             active_o
);

    div_state_e       state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] pend_val_q;
    logic             pend_q;
    logic             clk_div_q;
    logic             tick_q;
    logic             active_q;

    logic [DIV_W-1:0] wr_val_s;
    logic [DIV_W-1:0] ratio_d;
    logic [DIV_W-1:0] hi_last_s;
    logic [DIV_W-1:0] lo_last_s;
    logic             start_s;

    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] v);
        if (v < DIV_W'(MIN_DIV)) begin
            return DIV_W'(MIN_DIV);
        end else begin
            return v;
        end
    endfunction

    // Per-period quantities: last count of each half (HIGH takes the odd extra cycle) and the ratio a new period adopts.
    always_comb begin
        wr_val_s  = clamp_ratio(div_val_i);
        ratio_d   = pend_q ? pend_val_q : ratio_q;
        lo_last_s = (ratio_q >> 1) - DIV_W'(1);
        hi_last_s = ratio_q - (ratio_q >> 1) - DIV_W'(1);
        start_s   = en_i && ((state_q == ST_IDLE) ||
                             ((state_q == ST_LOW) && (cnt_q == lo_last_s)));
    end

    // Channel sequencer with registered outputs; ALIGN overrides the normal period flow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ratio_q    <= DIV_W'(DEF_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_div_q  <= 1'b0;
            tick_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (div_we_i) begin
                pend_val_q <= wr_val_s;
                pend_q     <= 1'b1;
            end
            if (align_i && en_i) begin
                state_q   <= ST_HIGH;
                cnt_q     <= '0;
                clk_div_q <= 1'b1;
                tick_q    <= 1'b1;
                active_q  <= 1'b1;
                ratio_q   <= div_we_i ? wr_val_s : ratio_d;
                pend_q    <= 1'b0;
            end else if (align_i) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                clk_div_q <= 1'b0;
                active_q  <= 1'b0;
            end else if (start_s) begin
                // A write on the boundary edge stays pending for the following period.
                state_q   <= ST_HIGH;
                cnt_q     <= '0;
                clk_div_q <= 1'b1;
                tick_q    <= 1'b1;
                active_q  <= 1'b1;
                ratio_q   <= ratio_d;
                pend_q    <= div_we_i;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                    end
                    ST_HIGH: begin
                        if (cnt_q == hi_last_s) begin
                            state_q   <= ST_LOW;
                            cnt_q     <= '0;
                            clk_div_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q == lo_last_s) begin
                            state_q  <= ST_IDLE;
                            cnt_q    <= '0;
                            active_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        clk_div_q <= 1'b0;
                        active_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clk_div_o = clk_div_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;
    assign active_o  = active_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing one input clock,
// reset and phase-align pulse.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_RATIO
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       en_i,
    input  logic                 align_i,
    input  logic [NCH-1:0]       div_we_i,
    input  logic [NCH*DIV_W-1:0] div_val_i,
    output logic [NCH-1:0]       clk_div_o,
    output logic [NCH-1:0]       tick_o,
    output logic [NCH-1:0]       pend_o,
    output logic [NCH-1:0]       active_o
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[i]),
            .align_i   (align_i),
            .div_we_i  (div_we_i[i]),
            .div_val_i (div_val_i[i*DIV_W +: DIV_W]),
            .clk_div_o (clk_div_o[i]),
            .tick_o    (tick_o[i]),
            .pend_o    (pend_o[i]),
            .active_o  (active_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a period/phase reference model queues the
// expected outputs of every cycle and a monitor compares them on the falling edge.
module tb_clk_div_bank;

    localparam int NCH     = 4;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 align;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       we;
    logic [NCH*DIV_W-1:0] val;
    logic [NCH-1:0]       clk_div;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pend;
    logic [NCH-1:0]       active;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NCH-1:0] clk_div;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
        logic [NCH-1:0] active;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: running flag, phase within the period and ratios per channel.
    bit m_run [NCH];
    int m_ph  [NCH];
    int m_cur [NCH];
    bit m_pend[NCH];
    int m_pv  [NCH];

    clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .align_i   (align),
        .div_we_i  (we),
        .div_val_i (val),
        .clk_div_o (clk_div),
        .tick_o    (tick),
        .pend_o    (pend),
        .active_o  (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model at each rising edge and queue the outputs it predicts.
    always @(posedge clk) begin : model
        exp_t e;
        int   wv;
        bit   at_end;
        for (int c = 0; c < NCH; c++) begin
            wv = int'(val[c*DIV_W +: DIV_W]);
            if (wv < 2) wv = 2;
            if (rst) begin
                m_run[c] = 1'b0; m_ph[c] = 0; m_cur[c] = DEF_DIV; m_pend[c] = 1'b0; m_pv[c] = 0;
            end else if (align && en[c]) begin
                m_cur[c]  = we[c] ? wv : (m_pend[c] ? m_pv[c] : m_cur[c]);
                m_pend[c] = 1'b0;
                m_run[c]  = 1'b1;
                m_ph[c]   = 0;
            end else begin
                at_end = m_run[c] && (m_ph[c] == m_cur[c] - 1);
                if (align) begin
                    m_run[c] = 1'b0;
                end else if (en[c] && (!m_run[c] || at_end)) begin
                    if (m_pend[c]) m_cur[c] = m_pv[c];
                    m_pend[c] = 1'b0;
                    m_run[c]  = 1'b1;
                    m_ph[c]   = 0;
                end else if (at_end) begin
                    m_run[c] = 1'b0;
                end else if (m_run[c]) begin
                    m_ph[c]++;
                end
                if (we[c]) begin
                    m_pend[c] = 1'b1;
                    m_pv[c]   = wv;
                end
            end
            e.clk_div[c] = m_run[c] && (m_ph[c] < (m_cur[c] + 1) / 2);
            e.tick[c]    = m_run[c] && (m_ph[c] == 0);
            e.pend[c]    = m_pend[c];
            e.active[c]  = m_run[c];
        end
        exp_q.push_back(e);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_clk_div", 32'(clk_div), 32'(e.clk_div));
            chk("sb_tick",    32'(tick),    32'(e.tick));
            chk("sb_pend",    32'(pend),    32'(e.pend));
            chk("sb_active",  32'(active),  32'(e.active));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input int c, input int v);
        we[c] = 1'b1;
        val[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    initial begin
        rst = 1'b1; align = 1'b0; en = '0; we = '0; val = '0;
        cyc(3);
        rst = 1'b0;
        chk("reset_outputs", 32'({clk_div, tick, pend, active}), 32'(0));

        // Default ratio 16 on channel 0.
        en = 4'b0001;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            chk("s1_clk_div0", 32'(clk_div[0]), 32'((i % 16) < 8));
            chk("s1_tick0",    32'(tick[0]),    32'((i % 16) == 0));
            chk("s1_others",   32'(clk_div[3:1]), 32'(0));
        end

        // Odd ratio 5 written while idle.
        rst = 1'b1; en = '0;
        cyc(2);
        rst = 1'b0;
        wr(1, 5);
        cyc(1);
        we = '0;
        chk("s2_pend_set", 32'(pend[1]), 32'(1));
        en = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("s2_clk_div1", 32'(clk_div[1]), 32'((i % 5) < 3));
            if (i == 0) chk("s2_pend_clr", 32'(pend[1]), 32'(0));
        end

        // Runtime change on channel 0: 16 -> 4 written mid-HIGH.
        en = 4'b0011;
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            chk("s3_clk_div0", 32'(clk_div[0]), 32'((i < 16) ? (i < 8) : (((i - 16) % 4) < 2)));
            if (i == 2) wr(0, 4);
            else we = '0;
        end

        // Align channels running at 6 and 10.
        wr(0, 6); wr(1, 10);
        cyc(1);
        we = '0;
        cyc(30);
        align = 1'b1;
        cyc(1);
        align = 1'b0;
        chk("s4_tick_aligned", 32'(tick[1:0]),    32'(2'b11));
        chk("s4_clk_aligned",  32'(clk_div[1:0]), 32'(2'b11));

        // Disable channel 0 mid-HIGH, then clamp a written 0 to ratio 2.
        en[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("s5_active0", 32'(active[0]), 32'(i < 5));
        end
        wr(0, 0);
        cyc(1);
        we = '0;
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("s5_clamp2", 32'(clk_div[0]), 32'((i % 2) == 0));
        end

        // Reset mid-operation.
        wr(2, 7);
        cyc(1);
        we = '0;
        rst = 1'b1; en = '0;
        cyc(1);
        rst = 1'b0;
        chk("s6_clk_div", 32'(clk_div), 32'(0));
        chk("s6_pend",    32'(pend),    32'(0));
        en = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            chk("s6_ratio16", 32'(clk_div[0]), 32'(i < 8));
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(1);
            we    = '0;
            align = ($urandom_range(63) == 0);
            rst   = ($urandom_range(599) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(15) == 0) en[c] = ~en[c];
                if ($urandom_range(11) == 0) begin
                    we[c] = 1'b1;
                    val[c*DIV_W +: DIV_W] = ($urandom_range(7) == 0) ?
                        DIV_W'($urandom_range(255)) : DIV_W'($urandom_range(12));
                end
            end
        end
        rst = 1'b0; align = 1'b0; we = '0;
        cyc(3);
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
